// File: rtl/mux_scan_ctrl.sv
// mux_scan_ctrl: sequences a 4:1 mux through enabled channels, samples d after a settle time, and hands off a 4-bit frame over valid/ready
// Ports: clk, rst_n (async active-low), start, cont, d (mux output), s1/s0 (registered select),
//        frame/frame_valid/frame_ready (downstream handshake), busy.
// Parameters: SETTLE_CYCLES (0..15), CH_MASK (bit k=1 scans channel k).
// Optional macro MUX_SCAN_VOTE_EN: each channel is captured on 3 consecutive edges and majority-voted.
module mux_scan_ctrl #(
    parameter int         SETTLE_CYCLES = 2,
    parameter logic [3:0] CH_MASK       = 4'b1111
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       cont,
    input  logic       d,
    output logic       s1,
    output logic       s0,
    output logic [3:0] frame,
    output logic       frame_valid,
    input  logic       frame_ready,
    output logic       busy
);
`ifdef MUX_SCAN_VOTE_EN
    localparam int EXTRA = 2;
`else
    localparam int EXTRA = 0;
`endif
    // The capture edge is the last SETTLE edge (counter==LAST); SAMPLE is the one-cycle
    // advance to the next channel, so each channel costs SETTLE_CYCLES+2(+2 when voting).
    localparam logic [4:0] LAST = 5'(SETTLE_CYCLES + EXTRA);

    typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} state_t;

    // Lowest enabled channel >= from; 4 means none left.
    function automatic logic [2:0] next_ch(input logic [2:0] from);
        logic [2:0] n;
        n = 3'd4;
        for (int i = 3; i >= 0; i--)
            if (CH_MASK[i] && 3'(i) >= from) n = 3'(i);
        return n;
    endfunction

    localparam logic [2:0] FIRST = next_ch(3'd0);

    state_t     state;
    logic [4:0] cnt;
    logic [3:0] shadow;
    logic       bit_val;
    logic       go;
    logic [1:0] sel;
    logic [2:0] after;
    logic [3:0] captured;

`ifdef MUX_SCAN_VOTE_EN
    logic [1:0] hist;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) hist <= '0;
        else        hist <= {hist[0], d};
    assign bit_val = (hist[1] & hist[0]) | (hist[1] & d) | (hist[0] & d);
`else
    assign bit_val = d;
`endif

    assign sel      = {s1, s0};
    assign after    = next_ch({1'b0, sel} + 3'd1);
    assign captured = shadow | (4'(bit_val) << sel);
    assign go       = (state == IDLE && start) || (state == DONE && frame_ready && cont);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            shadow      <= '0;
            {s1, s0}    <= 2'b00;
            frame       <= '0;
            frame_valid <= 1'b0;
            busy        <= 1'b0;
        end else if (go) begin
            busy   <= 1'b1;
            cnt    <= '0;
            shadow <= '0;
            if (FIRST[2]) begin
                frame       <= '0;
                frame_valid <= 1'b1;
                state       <= DONE;
            end else begin
                {s1, s0}    <= FIRST[1:0];
                frame_valid <= 1'b0;
                state       <= SETTLE;
            end
        end else begin
            case (state)
                SETTLE:
                    if (cnt == LAST) begin
                        shadow <= captured;
                        if (after[2]) begin
                            frame       <= captured;
                            frame_valid <= 1'b1;
                            state       <= DONE;
                        end else begin
                            state <= SAMPLE;
                        end
                    end else begin
                        cnt <= cnt + 5'd1;
                    end
                SAMPLE: begin
                    {s1, s0} <= after[1:0];
                    cnt      <= '0;
                    state    <= SETTLE;
                end
                DONE:
                    if (frame_ready) begin
                        frame_valid <= 1'b0;
                        busy        <= 1'b0;
                        state       <= IDLE;
                    end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_mux_scan_ctrl.sv
// tb_mux_scan_ctrl: randomized and directed checks of mux_scan_ctrl against a channel-schedule model
module tb_mux_scan_ctrl;
`ifdef MUX_SCAN_VOTE_EN
    localparam int X = 2;
`else
    localparam int X = 0;
`endif
    logic       clk = 0;
    logic       rst_n = 0;
    logic       cont = 0;
    logic       glitch = 0;
    logic [1:0] start_v = 0, ready_v = 0, d_v, s1_v, s0_v, fv_v, busy_v;
    logic [3:0] y_v [2];
    logic [3:0] fr_v [2];
    int         ncmp = 0, nfail = 0;

    always #5 clk = ~clk;

    assign d_v[0] = y_v[0][{s1_v[0], s0_v[0]}] ^ glitch;
    assign d_v[1] = y_v[1][{s1_v[1], s0_v[1]}];

    mux_scan_ctrl u_dut (
        .clk(clk), .rst_n(rst_n), .start(start_v[0]), .cont(cont), .d(d_v[0]),
        .s1(s1_v[0]), .s0(s0_v[0]), .frame(fr_v[0]), .frame_valid(fv_v[0]),
        .frame_ready(ready_v[0]), .busy(busy_v[0]));

    mux_scan_ctrl #(.SETTLE_CYCLES(0), .CH_MASK(4'b1010)) u_msk (
        .clk(clk), .rst_n(rst_n), .start(start_v[1]), .cont(1'b0), .d(d_v[1]),
        .s1(s1_v[1]), .s0(s0_v[1]), .frame(fr_v[1]), .frame_valid(fv_v[1]),
        .frame_ready(ready_v[1]), .busy(busy_v[1]));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int n_en(input logic [3:0] m);
        return int'(m[0]) + int'(m[1]) + int'(m[2]) + int'(m[3]);
    endfunction

    // j-th enabled channel in ascending order
    function automatic int ch_at(input logic [3:0] m, input int j);
        int c = 0;
        for (int k = 0; k < 4; k++)
            if (m[k]) begin
                if (c == j) return k;
                c++;
            end
        return 0;
    endfunction

    function automatic logic [1:0] sel_of(input int w);
        return {s1_v[w], s0_v[w]};
    endfunction

    // Kick a scan (start, or ready-with-cont handshake) and follow it cycle by cycle.
    task automatic follow(input int w, input logic [3:0] y, input logic [3:0] m, input int settle,
                          input bit use_start, input bit noise, input int glitch_t, input int stop_t);
        int p  = settle + 2 + X;
        int n  = n_en(m);
        int tv = n * p - 1;
        int j;
        @(negedge clk);
        y_v[w] = y;
        if (use_start) start_v[w] = 1; else ready_v[w] = 1;
        @(negedge clk);
        start_v[w] = 0;
        ready_v[w] = 0;
        for (int t = 0; t <= tv; t++) begin
            if (t > 0) @(negedge clk);
            j = t / p;
            if (j >= n) j = n - 1;
            chk($sformatf("sel[%0d]", t), sel_of(w), ch_at(m, j));
            chk($sformatf("busy[%0d]", t), busy_v[w], 1);
            chk($sformatf("valid[%0d]", t), fv_v[w], t >= tv);
            if (t == tv) chk("frame", fr_v[w], y & m);
            if (t == stop_t) return;
            glitch = (t == glitch_t);
            if (noise && t < tv) begin
                ready_v[w] = 1'($urandom);
                start_v[w] = 1'($urandom);
            end else begin
                ready_v[w] = 0;
                start_v[w] = 0;
            end
        end
        glitch = 0;
        ready_v[w] = 0;
        start_v[w] = 0;
    endtask

    task automatic hold(input int w, input int k, input logic [3:0] f, input logic [1:0] s);
        repeat (k) begin
            @(negedge clk);
            chk("hold_valid", fv_v[w], 1);
            chk("hold_frame", fr_v[w], f);
            chk("hold_sel", sel_of(w), s);
            chk("hold_busy", busy_v[w], 1);
        end
    endtask

    task automatic finish_frame(input int w);
        @(negedge clk);
        ready_v[w] = 1;
        @(negedge clk);
        ready_v[w] = 0;
        chk("post_valid", fv_v[w], 0);
        chk("post_busy", busy_v[w], 0);
    endtask

    initial begin
        logic [3:0] y;
        y_v[0] = 0;
        y_v[1] = 0;
        repeat (2) @(negedge clk);
        for (int w = 0; w < 2; w++) begin
            chk("rst_sel", sel_of(w), 0);
            chk("rst_frame", fr_v[w], 0);
            chk("rst_valid", fv_v[w], 0);
            chk("rst_busy", busy_v[w], 0);
        end
        rst_n = 1;

        follow(0, 4'b1101, 4'b1111, 2, 1, 0, -1, -1);
        hold(0, 10, 4'b1101, 2'b11);
        finish_frame(0);

        cont = 1;
        follow(0, 4'b1101, 4'b1111, 2, 1, 0, -1, -1);
        follow(0, 4'b1001, 4'b1111, 2, 0, 0, -1, -1);
        cont = 0;
        finish_frame(0);

        repeat (4) begin
            y = 4'($urandom);
            follow(0, y, 4'b1111, 2, 1, 1, -1, -1);
            hold(0, int'($urandom_range(0, 3)), y, 2'b11);
            finish_frame(0);
        end

        y = 4'($urandom) & 4'b1110;
        follow(0, y, 4'b1111, 2, 1, 0, 3, -1);
        finish_frame(0);

        follow(1, 4'b1111, 4'b1010, 0, 1, 1, -1, -1);
        hold(1, 2, 4'b1010, 2'b11);
        finish_frame(1);

        follow(0, 4'($urandom), 4'b1111, 2, 1, 0, -1, 2 * (4 + X) + 1);
        #2 rst_n = 0;
        #1;
        chk("arst_sel", sel_of(0), 0);
        chk("arst_frame", fr_v[0], 0);
        chk("arst_valid", fv_v[0], 0);
        chk("arst_busy", busy_v[0], 0);
        @(negedge clk);
        rst_n = 1;
        y = 4'($urandom);
        follow(0, y, 4'b1111, 2, 1, 0, -1, -1);
        finish_frame(0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end
endmodule

// File: doc/mux_scan_ctrl.md
Name: mux_scan_ctrl

Overview:
- Upstream sequencer for the 4:1 channel mux.
- Drives the mux select lines s1/s0, waits a programmable settle time, then samples the mux output d.
- Assembles the four samples into a 4-bit frame and hands the frame downstream over a valid/ready handshake.
- Supports single-shot and continuous scanning, plus a per-channel skip mask.

Parameters:
- SETTLE_CYCLES, 2: idle cycles between a select change and the sample of d; legal range 0..15.
- CH_MASK, 4'b1111: bit k=1 scans channel k; bit k=0 skips channel k, and frame[k] is forced to 0.

Ports:
- clk  input  1  single system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset; one clock domain; asserts asynchronously, deasserts synchronously to clk upstream.
- start  input  1  begin a scan; sampled only in IDLE.
- cont  input  1  continuous mode; sampled when a frame is accepted.
- d  input  1  mux output being sampled.
- s1  output  1  mux select MSB, registered.
- s0  output  1  mux select LSB, registered.
- frame  output  4  frame[k] = d sampled while {s1,s0}=k.
- frame_valid  output  1  frame holds a complete result.
- frame_ready  input  1  downstream accepts frame.
- busy  output  1  high from start acceptance until return to IDLE.

Behaviour:
- Reset (async, rst_n=0):
  - FSM goes to IDLE.
  - s1=0, s0=0, frame=0, frame_valid=0, busy=0, settle counter=0.
  - Applies mid-scan; any partial frame is discarded.
- FSM states: IDLE, SETTLE, SAMPLE, DONE.
- IDLE:
  - On start=1 at edge E0: busy=1, {s1,s0} set to the lowest enabled channel, counter cleared, go to SETTLE.
  - If CH_MASK=0: go directly to DONE with frame=0.
- SETTLE:
  - Counter increments each cycle.
  - When counter==SETTLE_CYCLES, go to SAMPLE.
  - SETTLE_CYCLES=0 means exactly one cycle is spent in SETTLE.
- SAMPLE (one cycle):
  - frame shadow bit [{s1,s0}] <= d.
  - If a higher enabled channel exists: select advances to it, counter cleared, go to SETTLE.
  - Otherwise: frame <= shadow (with this sample included), frame_valid <= 1, go to DONE.
- Timing with all channels enabled:
  - Channel k is sampled at edge E0 + (k+1)*(SETTLE_CYCLES+2) - 1.
  - frame_valid rises at the same edge as the channel-3 sample.
  - Default parameters: frame_valid high at E0+15.
- DONE:
  - frame and frame_valid are held stable until frame_valid&&frame_ready.
  - Select lines hold the last channel.
  - On handshake, frame_valid <= 0 at that edge. If cont=1: restart at the lowest enabled channel (as IDLE with start). Else: busy <= 0 and go to IDLE.
- frame_ready while frame_valid=0 is ignored.
- start while busy is ignored.
- cont deasserted mid-frame: the current frame completes; cont is only sampled at the handshake.
- Skipped channels: no select visit and no settle time spent; frame bit is 0.
- Shadow register is cleared when each scan begins.

Optional Feature:
- Macro MUX_SCAN_VOTE_EN.
- When defined:
  - SAMPLE lasts 3 cycles and captures d on 3 consecutive edges.
  - The stored bit is the majority of the 3 samples.
  - Per-channel period becomes SETTLE_CYCLES+4.
  - frame_valid at E0+23 with default parameters.
- When undefined: single-sample behaviour as described in Behaviour.

Test Plan:
1. Reset then scan: rst_n low then high; start pulse; d driven by the mux model with y0..y3 = 1,0,1,1. Required response: frame_valid at E0+15 with frame=4'b1101; s1/s0 step through 00,01,10,11; busy=1 throughout.
2. Backpressure: same stimulus, frame_ready held 0 for 10 cycles after frame_valid. Required response: frame and frame_valid stable and select held at 11; one cycle after a frame_ready pulse, frame_valid=0 and busy=0.
3. Continuous mode: cont=1; flip y2 between frames. Required response: back-to-back frames 1101 then 1001; the second scan's select returns to 00 on the handshake edge.
4. Mask: CH_MASK=4'b1010, SETTLE_CYCLES=0, all y=1. Required response: only select 01 and 11 are visited; frame=4'b1010 at E0+3.
5. Reset mid-scan: assert rst_n while in SETTLE of channel 2. Required response: all outputs 0 immediately (asynchronously); a fresh start produces a correct frame.
6. MUX_SCAN_VOTE_EN defined: d glitches high for one cycle during channel 0 sampling with y0=0. Required response: frame[0]=0; frame_valid at E0+23.
